i2s_mic_tdm: RTL

Parametrised behavioural/synthesisable model of an I2S/TDM digital microphone used in the audio-peripheral testbenches. It drives its samples into one slot of a multi-slot frame on a shared, tri-stated data line. Frames are started by a word-select rising edge from the I2S master under test. Samples are supplied by the bench through a valid/ready FIFO. The block supports I2S (one-bit delay) and left-justified/TDM (no delay) framing, MSB- or LSB-first ordering, and a daisy-chain pulse output.

---
 rtl/i2s_mic_tdm.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/i2s_mic_tdm.sv
// I2S/TDM microphone model: drives FIFO samples into one slot of a ws-started frame.
// Define I2S_MIC_TDM_STATUS_EN to build the sticky underrun/frame-error flags.
module i2s_mic_tdm #(
  parameter int WORD_W     = 24,
  parameter int SLOT_W     = 32,
  parameter int NUM_SLOTS  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              bclk,
  input  logic              rst,
  input  logic              ws,
  input  logic              cfg_mode,
  input  logic              cfg_lsb_first,
  input  logic [2:0]        cfg_slot,
  input  logic [WORD_W-1:0] sample_i,
  input  logic              sample_valid_i,
  output logic              sample_ready_o,
  output logic              dout,
  output logic              dout_oe,
  output logic              wso,
  output logic              underrun_o,
  output logic              frame_err_o
);

  localparam int FRAME_LEN = NUM_SLOTS * SLOT_W;
  localparam int KW        = $clog2(FRAME_LEN);
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [KW-1:0] LAST_K   = KW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, DELAY, FRAME} state_t;

  state_t            state_reg;
  logic              ws_q;
  logic [KW-1:0]     k_reg;
  logic              lsb_reg;
  logic [2:0]        slot_reg;
  logic [WORD_W-1:0] word_reg;
  logic              dout_reg;
  logic              last_reg;
  logic [AW:0]       wr_ptr_reg, rd_ptr_reg;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];

  logic              fs;
  logic              fifo_empty, fifo_full, push, pop;
  logic [AW:0]       fill;
  logic [31:0]       kk, base, b;
  logic              slot_ok, in_slot, first, last;
  logic [WORD_W-1:0] load_word, cur_word, shr, shl;
  logic              data_bit;

  assign fs = ws & ~ws_q;

  assign fill           = wr_ptr_reg - rd_ptr_reg;
  assign fifo_empty     = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full      = (fill == FULL_CNT);
  assign sample_ready_o = ~fifo_full;
  assign push           = sample_valid_i & ~fifo_full;
  assign load_word      = fifo_empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  // Position of the current frame bit relative to our own slot.
  assign kk      = 32'(k_reg);
  assign base    = 32'(slot_reg) * 32'(SLOT_W);
  assign b       = kk - base;
  assign slot_ok = 32'(slot_reg) < 32'(NUM_SLOTS);
  assign in_slot = (state_reg == FRAME) && slot_ok && (kk >= base) && (kk < base + 32'(SLOT_W));
  assign first   = in_slot && (b == 32'd0);
  assign last    = in_slot && (b == 32'(SLOT_W - 1));
  // A restart on this edge wins over the slot start, so nothing is popped.
  assign pop     = first & ~fs & ~fifo_empty;

  // The first slot bit comes straight from the FIFO head as it is popped.
  assign cur_word = first ? load_word : word_reg;
  assign shr      = cur_word >> b;
  assign shl      = cur_word << b;
  assign data_bit = (b < 32'(WORD_W)) ? (lsb_reg ? shr[0] : shl[WORD_W-1]) : 1'b0;

  assign dout = dout_oe ? dout_reg : 1'bz;

  always_ff @(posedge bclk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= sample_i;
  end

  always_ff @(posedge bclk) begin
    if (rst) begin
      ws_q       <= 1'b1;
      state_reg  <= IDLE;
      k_reg      <= '0;
      lsb_reg    <= 1'b0;
      slot_reg   <= '0;
      word_reg   <= '0;
      dout_reg   <= 1'b0;
      dout_oe    <= 1'b0;
      last_reg   <= 1'b0;
      wso        <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      ws_q <= ws;
      wso  <= last_reg;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (fs) begin
        lsb_reg   <= cfg_lsb_first;
        slot_reg  <= cfg_slot;
        state_reg <= cfg_mode ? FRAME : DELAY;
        k_reg     <= '0;
        dout_oe   <= 1'b0;
        dout_reg  <= 1'b0;
        last_reg  <= 1'b0;
      end else begin
        case (state_reg)
          DELAY: begin
            state_reg <= FRAME;
            k_reg     <= '0;
          end
          FRAME: begin
            if (k_reg == LAST_K) begin
              state_reg <= IDLE;
              k_reg     <= '0;
            end else begin
              k_reg <= k_reg + 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
        dout_oe  <= in_slot;
        dout_reg <= in_slot & data_bit;
        last_reg <= last;
        if (first) word_reg <= load_word;
      end
    end
  end

`ifdef I2S_MIC_TDM_STATUS_EN
  always_ff @(posedge bclk) begin
    if (rst) begin
      underrun_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      if (first && !fs && fifo_empty) underrun_o <= 1'b1;
      if (fs && state_reg != IDLE)    frame_err_o <= 1'b1;
    end
  end
`else
  assign underrun_o  = 1'b0;
  assign frame_err_o = 1'b0;
`endif

endmodule
